boolean_exp_unit: RTL and testbench
===================================

// Module: boolean_exp_unit
// PURPOSE
//   Registered five-function Boolean evaluator over four 1-bit inputs A,B,C,D.
//   Each clock it samples the inputs (when in_valid) and presents five fixed
//   combinational functions Y1..Y5 on registered outputs, one cycle later.
//   Serves as the logic-function block of the DSD exercise datapath.
// PARAMETERS
//   none (all widths fixed at 1 bit; functions hard-wired)
// PORTS
//   clk       input   1  single clock, all state on rising edge
//   rst       input   1  synchronous, active-high reset
//   in_valid  input   1  sample A..D this cycle when 1
//   A         input   1  operand (MSB of minterm index ABCD)
//   B         input   1  operand
//   C         input   1  operand
//   D         input   1  operand (LSB of minterm index)
//   Y1        output  1  registered f1
//   Y2        output  1  registered f2
//   Y3        output  1  registered f3
//   Y4        output  1  registered f4
//   Y5        output  1  registered f5
//   out_valid output  1  1 for one cycle after each accepted sample
// BEHAVIOUR
//   Interface: one clock (clk); rst synchronous, active-high; no other clocks/resets.
//   Functions (m = minterm index 8A+4B+2C+D):
//     f1 = A&B | C&~D                    (SOP; m 2,6,10,12,13,14,15)
//     f2 = (A|~B) & (C|D)                (POS; m 1,2,3,9,10,11,13,14,15)
//     f3 = A^B^C^D                       (odd parity)
//     f4 = ~(B^D)                        (m 0,2,5,7,8,10,13,15)
//     f5 = at least three of A,B,C,D = 1 (m 7,11,13,14,15)
//   Reset: on posedge clk with rst=1 -> Y1..Y5=0, out_valid=0; rst wins over in_valid.
//   Accept: posedge clk, rst=0, in_valid=1 -> Yn <= fn(A,B,C,D), out_valid <= 1.
//   Idle: posedge clk, rst=0, in_valid=0 -> Y1..Y5 hold, out_valid <= 0.
//   Latency exactly 1 cycle; throughput one sample per cycle, back-to-back allowed.
//   No combinational path from inputs to outputs; inputs are never latched otherwise.
//   X/Z on A..D while in_valid=0 must not affect outputs.
//   Reset asserted mid-stream discards the sample on that edge; first valid
//   sample after rst deasserts produces results on the following edge.
// TESTING
//   rst=1 two cycles, any inputs -> Y1..Y5=00000, out_valid=0.
//   Sweep ABCD 0000..1111 with in_valid=1, one per cycle -> each Yn matches its
//     minterm list one cycle later; out_valid=1 throughout the sweep.
//   ABCD=0000 -> Y1..Y5=0,0,0,1,0; ABCD=0010 -> 1,1,1,1,0; ABCD=0100 -> 0,0,1,0,0.
//   ABCD=1101 -> 1,1,1,1,1; ABCD=1111 -> 1,1,0,1,1.
//   Load 1101, then in_valid=0 with ABCD=0000 for 3 cycles -> Y hold 11111, out_valid=0.
//   rst=1 together with in_valid=1, ABCD=1111 -> outputs 00000, out_valid=0 next cycle.

Source files
------------

// File: rtl/boolean_exp_unit.sv
// Registered five-function Boolean evaluator over A,B,C,D.
// One-cycle latency, one sample per clock, outputs hold while idle.
module boolean_exp_unit (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic out_valid
);

  typedef struct packed {
    logic f1;
    logic f2;
    logic f3;
    logic f4;
    logic f5;
  } fn_t;

  fn_t fn;
  fn_t res;
  logic [2:0] ones;

  always_comb begin
    ones = {2'b00, A} + {2'b00, B}
         + {2'b00, C} + {2'b00, D};
    fn.f1 = (A & B) | (C & ~D);
    fn.f2 = (A | ~B) & (C | D);
    fn.f3 = A ^ B ^ C ^ D;
    fn.f4 = ~(B ^ D);
    fn.f5 = (ones >= 3'd3);
  end

  // Inputs are only looked at when in_valid, so X/Z while idle is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      res       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      res       <= fn;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign Y1 = res.f1;
  assign Y2 = res.f2;
  assign Y3 = res.f3;
  assign Y4 = res.f4;
  assign Y5 = res.f5;

endmodule

// File: tb/tb_boolean_exp_unit.sv
// Scoreboard bench for boolean_exp_unit: expectations come from
// minterm-list masks, pushed at drive time and popped after each edge.
module tb_boolean_exp_unit;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic A, B, C, D;
  logic Y1, Y2, Y3, Y4, Y5, out_valid;

  int errors = 0;
  int checks = 0;

  logic [15:0] m1 = 16'hF444;
  logic [15:0] m2 = 16'hEE0E;
  logic [15:0] m3 = 16'h6996;
  logic [15:0] m4 = 16'hA5A5;
  logic [15:0] m5 = 16'hE880;

  logic [4:0] model_y = '0;
  logic       model_v = 1'b0;
  logic [5:0] sb[$];

  boolean_exp_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .C(C), .D(D),
    .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .Y5(Y5),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] observed();
    return {Y1, Y2, Y3, Y4, Y5, out_valid};
  endfunction

  // Drive one cycle, update the model, push the expectation, step the edge.
  task automatic cycle(input logic r, input logic v,
                       input logic [3:0] abcd);
    rst = r;
    in_valid = v;
    {A, B, C, D} = abcd;
    if (r) begin
      model_y = '0;
      model_v = 1'b0;
    end else if (v) begin
      model_y = {m1[abcd], m2[abcd], m3[abcd],
                 m4[abcd], m5[abcd]};
      model_v = 1'b1;
    end else begin
      model_v = 1'b0;
    end
    sb.push_back({model_y, model_v});
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output logic [5:0] e, input string name);
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", name);
      e = 'x;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    logic [5:0] e;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      pop_exp(e, "reset");
      checks++;
      if (observed() !== e || observed() !== 6'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got %b want %b",
                 i, observed(), 6'b0);
      end
    end
  endtask

  task automatic test_sweep();
    logic [5:0] e;
    for (int m = 0; m < 16; m++) begin
      cycle(1'b0, 1'b1, 4'(m));
      pop_exp(e, "sweep");
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL sweep m=%0d: got %b want %b",
                 m, observed(), e);
      end
    end
  endtask

  task automatic test_vectors();
    logic [5:0] e;
    logic [3:0] vin[5] = '{4'b0000, 4'b0010, 4'b0100,
                           4'b1101, 4'b1111};
    logic [4:0] vout[5] = '{5'b00010, 5'b11110, 5'b00100,
                            5'b11111, 5'b11011};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, vin[i]);
      pop_exp(e, "vector");
      checks++;
      if (observed() !== e ||
          observed() !== {vout[i], 1'b1}) begin
        errors++;
        $display("FAIL vector abcd=%b: got %b want %b",
                 vin[i], observed(), {vout[i], 1'b1});
      end
    end
  endtask

  task automatic test_hold();
    logic [5:0] e;
    cycle(1'b0, 1'b1, 4'b1101);
    pop_exp(e, "hold_load");
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL hold_load: got %b want %b", observed(), e);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, (i == 3) ? 4'bxxxx : 4'b0000);
      pop_exp(e, "hold");
      checks++;
      if (observed() !== e || observed() !== 6'b111110) begin
        errors++;
        $display("FAIL hold[%0d]: got %b want %b",
                 i, observed(), 6'b111110);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    cycle(1'b0, 1'b1, 4'b1101);
    pop_exp(e, "rst_pre");
    cycle(1'b1, 1'b1, 4'b1111);
    pop_exp(e, "rst_mid");
    checks++;
    if (observed() !== e || observed() !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid: got %b want %b", observed(), 6'b0);
    end
    cycle(1'b0, 1'b1, 4'b0010);
    pop_exp(e, "rst_after");
    checks++;
    if (observed() !== e || observed() !== 6'b111101) begin
      errors++;
      $display("FAIL rst_after: got %b want %b",
               observed(), 6'b111101);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)));
      pop_exp(e, "b2b");
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL b2b[%0d]: got %b want %b",
                 i, observed(), e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    {A, B, C, D} = 4'b0000;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_vectors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
